// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared types and constants for the microprogrammed
// datapath sequencer.
//   - seq_op_e  : sequencing operation carried by each microcode entry
//   - COND_*    : branch condition encodings (flag select, bit 2 inverts)
//   - state_e   : sequencer FSM states
//   - uc_ctl_t  : {seq_op, cond} field pair of an entry
//   - uc_entry_t: full entry layout at the default widths (55-bit cw, 4-bit target)
package datapath_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_NEXT   = 2'b00,
        SEQ_BRANCH = 2'b01,
        SEQ_JUMP   = 2'b10,
        SEQ_END    = 2'b11
    } seq_op_e;

    localparam logic [2:0] COND_Z  = 3'd0;
    localparam logic [2:0] COND_N  = 3'd1;
    localparam logic [2:0] COND_C  = 3'd2;
    localparam logic [2:0] COND_V  = 3'd3;
    localparam logic [2:0] COND_NZ = 3'd4;
    localparam logic [2:0] COND_NN = 3'd5;
    localparam logic [2:0] COND_NC = 3'd6;
    localparam logic [2:0] COND_NV = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        seq_op_e    seq_op;
        logic [2:0] cond;
    } uc_ctl_t;

    localparam int UC_CW_W = 55;
    localparam int UC_AW   = 4;

    typedef struct packed {
        logic [UC_CW_W-1:0] cw;
        uc_ctl_t            ctl;
        logic [UC_AW-1:0]   target;
    } uc_entry_t;

endpackage

// File: rtl/datapath_sequencer_cond.sv
// seq_cond_eval: combinational branch-condition evaluator.
// Ports:
//   cond    in  3  condition select (COND_Z .. COND_NV)
//   V,C,N,Z in  1  datapath flags for the word currently presented
//   taken   out 1  branch condition is true
module seq_cond_eval
    import datapath_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       V,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_Z:  taken = Z;
            COND_N:  taken = N;
            COND_C:  taken = C;
            COND_V:  taken = V;
            COND_NZ: taken = !Z;
            COND_NN: taken = !N;
            COND_NC: taken = !C;
            COND_NV: taken = !V;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: microprogrammed control unit driving the datapath
// control word. A writable microcode store is stepped from start_addr,
// branching on V/C/N/Z, ending with a one-cycle done pulse; a watchdog
// aborts runs longer than MAX_STEPS words (sticky timeout).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load_en/addr/data write one entry {cw, seq_op, cond, target} (IDLE/DONE only)
//   start, start_addr begin a run at start_addr (IDLE only)
//   V, C, N, Z        datapath flags for the presented word
//   control_word      cw of mem[upc] in RUN, NOP (0) otherwise
//   busy, done        run in progress / completion pulse
//   timeout           sticky watchdog abort flag
//   upc               address of the presented word
// Config macro: SEQ_SINGLE_STEP_EN adds input 'step'; RUN then advances
// (and presents a non-NOP word) only in cycles with step=1.
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter  int CW_W      = 55,
    parameter  int DEPTH     = 16,
    parameter  int MAX_STEPS = 1024,
    localparam int AW        = $clog2(DEPTH),
    localparam int EW        = CW_W + 5 + AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [EW-1:0]   load_data,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            V,
    input  logic            C,
    input  logic            N,
    input  logic            Z,
    output logic [CW_W-1:0] control_word,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [AW-1:0]   upc
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    logic [EW-1:0]    mem_q [DEPTH];
    state_e           state_q;
    logic [AW-1:0]    upc_q, upc_d, upc_inc, target;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             busy_q, done_q, timeout_q;
    logic [EW-1:0]    entry;
    logic [CW_W-1:0]  cw_cur;
    uc_ctl_t          ctl;
    logic             taken, adv, wdog_hit;

`ifdef SEQ_SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // Asynchronous read: a write landing at the start edge is already
    // visible to the first presented word.
    assign entry  = mem_q[upc_q];
    assign cw_cur = entry[EW-1 -: CW_W];
    assign ctl    = uc_ctl_t'(entry[AW+4:AW]);
    assign target = entry[AW-1:0];

    seq_cond_eval u_cond (
        .cond  (ctl.cond),
        .V     (V),
        .C     (C),
        .N     (N),
        .Z     (Z),
        .taken (taken)
    );

    assign upc_inc = (upc_q == AW'(DEPTH - 1)) ? '0 : upc_q + AW'(1);

    always_comb begin
        upc_d = upc_inc;
        unique case (ctl.seq_op)
            SEQ_BRANCH: upc_d = taken ? target : upc_inc;
            SEQ_JUMP:   upc_d = target;
            default:    upc_d = upc_inc;
        endcase
    end

    // cnt_q = words already issued; abort when the next one would be
    // word number MAX_STEPS+1.
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign wdog_hit = (cnt_inc == CNT_W'(MAX_STEPS));

    // Store is deliberately not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (load_en && state_q != RUN) mem_q[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            upc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= RUN;
                        upc_q     <= start_addr;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (adv) begin
                        cnt_q <= cnt_inc;
                        if (ctl.seq_op == SEQ_END) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (wdog_hit) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            upc_q <= upc_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign control_word = (state_q == RUN && adv) ? cw_cur : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign upc          = upc_q;

endmodule
